// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetched words and queues uops in a skid FIFO.
// Ports: fetch side (opcode, pc_in, uop_valid_in, decode_stall), flush,
// execute side (dec_valid/dec_ready + decoded fields), sticky overflow_err.
module decode_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INST_WIDTH-1:0] opcode,
    input  logic                  uop_valid_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  system_flush,
    output logic                  decode_stall,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic [3:0]            dec_class,
    output logic [4:0]            dec_rd,
    output logic [4:0]            dec_rs1,
    output logic [4:0]            dec_rs2,
    output logic [2:0]            dec_funct3,
    output logic [6:0]            dec_funct7,
    output logic [31:0]           dec_imm,
    output logic                  overflow_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [3:0] C_NOP   = 4'd0;
    localparam logic [3:0] C_LUI   = 4'd1;
    localparam logic [3:0] C_AUIPC = 4'd2;
    localparam logic [3:0] C_JAL   = 4'd3;
    localparam logic [3:0] C_JALR  = 4'd4;
    localparam logic [3:0] C_BR    = 4'd5;
    localparam logic [3:0] C_LOAD  = 4'd6;
    localparam logic [3:0] C_STORE = 4'd7;
    localparam logic [3:0] C_OPIMM = 4'd8;
    localparam logic [3:0] C_OP    = 4'd9;
    localparam logic [3:0] C_ILL   = 4'd15;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [3:0]            cls;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [2:0]            f3;
        logic [6:0]            f7;
        logic [31:0]           imm;
    } uop_t;

    uop_t            mem_q [DEPTH];
    uop_t            mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [31:0]     inst;
    logic [6:0]      op;
    uop_t            uop;
    logic            push, pop, full;

    assign inst = opcode[31:0];
    assign op   = inst[6:0];

    always_comb begin
        uop     = '0;
        uop.pc  = pc_in;
        uop.rs1 = inst[19:15];
        uop.rs2 = inst[24:20];
        uop.f3  = inst[14:12];
        uop.f7  = inst[31:25];
        uop.rd  = inst[11:7];
        uop.imm = '0;
        unique case (1'b1)
            op == 7'b0110111: begin
                uop.cls = C_LUI;
                uop.imm = {inst[31:12], 12'b0};
            end
            op == 7'b0010111: begin
                uop.cls = C_AUIPC;
                uop.imm = {inst[31:12], 12'b0};
            end
            op == 7'b1101111: begin
                uop.cls = C_JAL;
                uop.imm = {{11{inst[31]}}, inst[31], inst[19:12],
                           inst[20], inst[30:21], 1'b0};
            end
            op == 7'b1100111: begin
                uop.cls = C_JALR;
                uop.imm = {{20{inst[31]}}, inst[31:20]};
            end
            op == 7'b1100011: begin
                uop.cls = C_BR;
                uop.rd  = '0;
                uop.imm = {{19{inst[31]}}, inst[31], inst[7],
                           inst[30:25], inst[11:8], 1'b0};
            end
            op == 7'b0000011: begin
                uop.cls = C_LOAD;
                uop.imm = {{20{inst[31]}}, inst[31:20]};
            end
            op == 7'b0100011: begin
                uop.cls = C_STORE;
                uop.rd  = '0;
                uop.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            op == 7'b0010011: begin
                uop.cls = C_OPIMM;
                uop.imm = {{20{inst[31]}}, inst[31:20]};
            end
            op == 7'b0110011: begin
                uop.cls = C_OP;
            end
            op == 7'b0001111,
            op == 7'b1110011: begin
                uop.cls = C_NOP;
                uop.rd  = '0;
            end
            default: begin
                // Also covers inst[1:0] != 2'b11 (compressed space).
                uop.cls = C_ILL;
                uop.rd  = '0;
            end
        endcase
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full = (count_q == CW'(DEPTH));
    assign pop  = (count_q != '0) & dec_ready & ~system_flush;
    assign push = uop_valid_in & ~system_flush & (~full | pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (system_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = uop;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push & ~pop) begin
                count_d = count_q + CW'(1);
            end else if (pop & ~push) begin
                count_d = count_q - CW'(1);
            end
            if (uop_valid_in & full & ~pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // One slot of slack absorbs the uop fetch already has in flight.
    assign decode_stall = (count_q >= CW'(DEPTH - 1));
    assign dec_valid    = (count_q != '0);
    assign overflow_err = ovf_q;

    assign dec_pc     = mem_q[rd_ptr_q].pc;
    assign dec_class  = mem_q[rd_ptr_q].cls;
    assign dec_rd     = mem_q[rd_ptr_q].rd;
    assign dec_rs1    = mem_q[rd_ptr_q].rs1;
    assign dec_rs2    = mem_q[rd_ptr_q].rs2;
    assign dec_funct3 = mem_q[rd_ptr_q].f3;
    assign dec_funct7 = mem_q[rd_ptr_q].f7;
    assign dec_imm    = mem_q[rd_ptr_q].imm;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a queue-based reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_decode_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] opcode;
    logic        uop_valid_in;
    logic [31:0] pc_in;
    logic        system_flush;
    logic        decode_stall;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [3:0]  dec_class;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [31:0] dec_imm;
    logic        overflow_err;

    always #5 clk = ~clk;

    decode_stage #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .uop_valid_in(uop_valid_in),
        .pc_in       (pc_in),
        .system_flush(system_flush),
        .decode_stall(decode_stall),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_pc      (dec_pc),
        .dec_class   (dec_class),
        .dec_rd      (dec_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_funct3  (dec_funct3),
        .dec_funct7  (dec_funct7),
        .dec_imm     (dec_imm),
        .overflow_err(overflow_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } exp_t;

    exp_t mq[$];
    bit   m_ovf;
    int   n_vec;
    int   n_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] i,
                                     input logic [31:0] pc);
        exp_t        e;
        logic signed [31:0] s;
        logic [31:0] sx;
        s     = i;
        sx    = 32'(s >>> 31);
        e.pc  = pc;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.f3  = i[14:12];
        e.f7  = i[31:25];
        case (i[6:0])
            7'h37:        e.cls = 4'd1;
            7'h17:        e.cls = 4'd2;
            7'h6F:        e.cls = 4'd3;
            7'h67:        e.cls = 4'd4;
            7'h63:        e.cls = 4'd5;
            7'h03:        e.cls = 4'd6;
            7'h23:        e.cls = 4'd7;
            7'h13:        e.cls = 4'd8;
            7'h33:        e.cls = 4'd9;
            7'h0F, 7'h73: e.cls = 4'd0;
            default:      e.cls = 4'd15;
        endcase
        case (e.cls)
            4'd4, 4'd6, 4'd8:
                e.imm = 32'(s >>> 20);
            4'd7:
                e.imm = (32'(s >>> 25) << 5) | 32'(i[11:7]);
            4'd5:
                e.imm = (sx << 12) | (32'(i[7]) << 11)
                      | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            4'd1, 4'd2:
                e.imm = i & 32'hFFFF_F000;
            4'd3:
                e.imm = (sx << 20) | (32'(i[19:12]) << 12)
                      | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default:
                e.imm = 32'd0;
        endcase
        if (e.cls inside {4'd0, 4'd5, 4'd7, 4'd15}) e.rd = 5'd0;
        else e.rd = i[11:7];
        return e;
    endfunction

    task automatic check_outputs();
        exp_t h;
        chk("valid", 32'(dec_valid), 32'(mq.size() != 0));
        chk("stall", 32'(decode_stall), 32'(mq.size() >= DEPTH - 1));
        chk("ovf", 32'(overflow_err), 32'(m_ovf));
        if (mq.size() != 0) begin
            h = mq[0];
            chk("pc", dec_pc, h.pc);
            chk("class", 32'(dec_class), 32'(h.cls));
            chk("rd", 32'(dec_rd), 32'(h.rd));
            chk("rs1", 32'(dec_rs1), 32'(h.rs1));
            chk("rs2", 32'(dec_rs2), 32'(h.rs2));
            chk("funct3", 32'(dec_funct3), 32'(h.f3));
            chk("funct7", 32'(dec_funct7), 32'(h.f7));
            chk("imm", dec_imm, h.imm);
        end
    endtask

    // Drive one cycle (called right after a falling edge), update the
    // model for the coming rising edge, then check on the next fall.
    task automatic cycle(input bit vin, input logic [31:0] op,
                         input logic [31:0] pc, input bit fl,
                         input bit rdy);
        int  n;
        bit  pp;
        uop_valid_in = vin;
        opcode       = op;
        pc_in        = pc;
        system_flush = fl;
        dec_ready    = rdy;
        n  = mq.size();
        pp = (n != 0) && rdy && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (vin) begin
                if (n < DEPTH || pp) mq.push_back(ref_dec(op, pc));
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [14];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                7'h13, 7'h33, 7'h0F, 7'h73, 7'h0B, 7'h7F, 7'h10};
        r = $urandom();
        if ($urandom_range(0, 7) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 13)]};
    endfunction

    initial begin
        n_vec        = 0;
        n_err        = 0;
        m_ovf        = 1'b0;
        reset_n      = 1'b0;
        opcode       = '0;
        uop_valid_in = 1'b0;
        pc_in        = '0;
        system_flush = 1'b0;
        dec_ready    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_outputs();
        chk("rst_pc", dec_pc, 32'h0);
        chk("rst_imm", dec_imm, 32'h0);
        chk("rst_class", 32'(dec_class), 32'h0);
        chk("rst_rd", 32'(dec_rd), 32'h0);

        cycle(1, 32'h0050_0093, 32'h100, 0, 1);
        chk("addi_valid", 32'(dec_valid), 32'h1);
        chk("addi_class", 32'(dec_class), 32'd8);
        chk("addi_rd", 32'(dec_rd), 32'd1);
        chk("addi_rs1", 32'(dec_rs1), 32'd0);
        chk("addi_imm", dec_imm, 32'd5);
        chk("addi_pc", dec_pc, 32'h100);
        cycle(1, 32'hFE00_0EE3, 32'h104, 0, 1);
        chk("beq_class", 32'(dec_class), 32'd5);
        chk("beq_rd", 32'(dec_rd), 32'd0);
        chk("beq_imm", dec_imm, 32'hFFFF_FFFC);
        cycle(1, 32'h1234_52B7, 32'h108, 0, 1);
        chk("lui_class", 32'(dec_class), 32'd1);
        chk("lui_rd", 32'(dec_rd), 32'd5);
        chk("lui_imm", dec_imm, 32'h1234_5000);
        cycle(0, 32'h0, 32'h0, 0, 1);

        cycle(1, 32'h0050_0093, 32'h200, 0, 0);
        chk("stall_one", 32'(decode_stall), 32'h1);
        cycle(1, 32'h0010_0113, 32'h204, 0, 0);
        cycle(1, 32'h0020_0193, 32'h208, 0, 0);
        chk("ovf_set", 32'(overflow_err), 32'h1);
        cycle(0, 32'h0, 32'h0, 0, 1);
        chk("order_2nd", dec_pc, 32'h204);
        cycle(0, 32'h0, 32'h0, 0, 1);
        chk("drained", 32'(dec_valid), 32'h0);

        cycle(1, 32'h0000_0033, 32'h300, 0, 0);
        cycle(1, 32'h0000_0033, 32'h304, 0, 0);
        cycle(1, 32'h0000_0013, 32'h308, 1, 1);
        chk("flush_valid", 32'(dec_valid), 32'h0);
        chk("flush_stall", 32'(decode_stall), 32'h0);
        cycle(0, 32'h0, 32'h0, 0, 1);

        cycle(1, 32'h0000_007F, 32'h400, 0, 1);
        chk("ill1_class", 32'(dec_class), 32'd15);
        cycle(1, 32'h0000_0090, 32'h404, 0, 1);
        chk("ill2_class", 32'(dec_class), 32'd15);
        chk("ill2_rd", 32'(dec_rd), 32'd0);
        chk("ill2_imm", dec_imm, 32'd0);
        cycle(1, 32'h0000_000F, 32'h408, 0, 1);
        chk("fence_class", 32'(dec_class), 32'd0);

        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 9) < 7, rand_inst(), $urandom(),
                  $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 6);
        end

        cycle(1, 32'h0000_0033, 32'h500, 0, 0);
        cycle(1, 32'h0000_0033, 32'h504, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        chk("arst_valid", 32'(dec_valid), 32'h0);
        chk("arst_stall", 32'(decode_stall), 32'h0);
        chk("arst_ovf", 32'(overflow_err), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1, 32'h0030_0213, 32'h600, 0, 0);
        chk("post_rst_pc", dec_pc, 32'h600);
        cycle(1, 32'h0040_0293, 32'h604, 0, 1);
        cycle(0, 32'h0, 32'h0, 0, 1);
        cycle(0, 32'h0, 32'h0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
